// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame layout: 4 header bytes (big-endian length L), L payload bytes, 1 XOR checksum byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } ldr_state_t;

    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (host -> loader) and imem byte write port (loader -> memory).
// Stream: a byte moves on a rising edge where ByteValid && ByteReady; the host holds ByteIn stable while ByteValid is high and not yet accepted.
interface imem_loader_byte_if #(
    parameter int WD = 8
) ();
    logic [WD-1:0] ByteIn;
    logic          ByteValid;
    logic          ByteReady;

    modport master (output ByteIn, output ByteValid, input  ByteReady);
    modport slave  (input  ByteIn, input  ByteValid, output ByteReady);
endinterface

interface imem_loader_wr_if #(
    parameter int WAD = 16,
    parameter int WD  = 8
) ();
    logic           WrEn;
    logic [WAD-1:0] WrAddr;
    logic [WD-1:0]  WrData;

    modport master (output WrEn, output WrAddr, output WrData);
    modport slave  (input  WrEn, input  WrAddr, input  WrData);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// and holds the CPU in reset until the image is complete and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WAD = 16,
    parameter int WD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    imem_loader_byte_if.slave    bs,
    imem_loader_wr_if.master     wr,
    output logic                 CpuHold,
    output logic                 Done,
    output logic                 Err,
    output logic [WAD:0]         ByteCount,
    output ldr_state_t           dbg_state
);

    ldr_state_t     state_q;
    logic [31:0]    hdr_q;
    logic [1:0]     hdr_cnt_q;
    logic [WAD:0]   cnt_q;
    logic [WD-1:0]  csum_q;
    logic           wr_en_q;
    logic [WAD-1:0] wr_addr_q;
    logic [WD-1:0]  wr_data_q;
    logic           hold_q;
    logic           done_q;
    logic           err_q;

    logic           ready;
    logic           accept;
    logic [31:0]    hdr_d;
    logic [WAD:0]   cnt_d;
    logic           hdr_last;
    logic           len_bad;
    logic           data_last;

    assign ready     = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign accept    = bs.ByteValid && ready;
    assign hdr_d     = {hdr_q[23:0], bs.ByteIn};
    assign cnt_d     = cnt_q + 1'b1;
    assign hdr_last  = (hdr_cnt_q == 2'(HDR_BYTES - 1));
    // Length must fit the memory exactly (L == 2**WAD allowed) and be whole words.
    assign len_bad   = ({32'd0, hdr_d} > (64'd1 << WAD)) || (hdr_d[1:0] != 2'b00);
    assign data_last = (32'(cnt_d) == hdr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        state_q   <= HDR;
                        hold_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        hdr_q     <= '0;
                        hdr_cnt_q <= '0;
                        cnt_q     <= '0;
                        csum_q    <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        hdr_q     <= hdr_d;
                        hdr_cnt_q <= hdr_cnt_q + 1'b1;
                        if (hdr_last) begin
                            if (hdr_d == 32'd0) begin
                                state_q <= CSUM;
                            end else if (len_bad) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    // The write trails the accept by one cycle, so the final byte lands in CSUM.
                    if (accept) begin
                        csum_q    <= csum_q ^ bs.ByteIn;
                        cnt_q     <= cnt_d;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q[WAD-1:0];
                        wr_data_q <= bs.ByteIn;
                        if (data_last) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (bs.ByteIn == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bs.ByteReady = ready;
    assign wr.WrEn      = wr_en_q;
    assign wr.WrAddr    = wr_addr_q;
    assign wr.WrData    = wr_data_q;
    assign CpuHold      = hold_q;
    assign Done         = done_q;
    assign Err          = err_q;
    assign ByteCount    = cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed byte streams, models the imem
// byte array and scoreboards every write against an expected queue.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int WAD = 16;
    localparam int WD  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           Start;
    logic           CpuHold;
    logic           Done;
    logic           Err;
    logic [WAD:0]   ByteCount;
    ldr_state_t     dbg_state;

    imem_loader_byte_if #(.WD(WD))            bs ();
    imem_loader_wr_if   #(.WAD(WAD), .WD(WD)) wr ();

    imem_loader #(.WAD(WAD), .WD(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .bs        (bs),
        .wr        (wr),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Err       (Err),
        .ByteCount (ByteCount),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [23:0]    exp_q[$];
    logic [7:0]     tx_q[$];
    logic [7:0]     mem [0:(1<<WAD)-1];
    int             wr_count = 0;
    logic [WAD-1:0] last_addr = '0;
    logic           sb_en = 1'b1;
    int             w0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model and write scoreboard, sampled away from the rising edge.
    always @(negedge clk) begin
        if (wr.WrEn === 1'b1) begin
            wr_count++;
            last_addr = wr.WrAddr;
            mem[wr.WrAddr] = wr.WrData;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {wr.WrAddr, wr.WrData}, 24'hxxxxxx);
                end else begin
                    check("wr_addr_data", {wr.WrAddr, wr.WrData}, exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks: all inputs change 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bs.ByteIn    = b;
        bs.ByteValid = 1'b1;
        while (bs.ByteReady !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (bs.ByteReady !== 1'b1) begin
            check("send_timeout", {63'd0, bs.ByteReady}, 64'd1);
            bs.ByteValid = 1'b0;
            return;
        end
        tick(1);
        bs.ByteValid = 1'b0;
        tick(gap);
    endtask

    task automatic send_all(input int gap);
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), gap);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic push_frame_1(input logic [7:0] csum);
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h50, 8'h00, csum};
        exp_q = '{24'h0000_13, 24'h0001_00, 24'h0002_50, 24'h0003_00};
    endtask

    function automatic logic [31:0] fetch0();
        return {mem[0], mem[1], mem[2], mem[3]};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        Start        = 1'b0;
        bs.ByteIn    = '0;
        bs.ByteValid = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_state",   dbg_state,    IDLE);
        check("rst_ready",   bs.ByteReady, 0);
        check("rst_wren",    wr.WrEn,      0);
        check("rst_hold",    CpuHold,      0);
        check("rst_done",    Done,         0);
        check("rst_err",     Err,          0);
        check("rst_count",   ByteCount,    0);
        check("rst_addr",    wr.WrAddr,    0);
        check("rst_data",    wr.WrData,    0);

        // 1: good 4-byte image
        pulse_start();
        check("s1_hold_hdr", CpuHold,   1);
        check("s1_state",    dbg_state, HDR);
        push_frame_1(8'h43);
        w0 = wr_count;
        send_all(0);
        check("s1_done",     Done,              1);
        check("s1_hold",     CpuHold,           0);
        check("s1_err",      Err,               0);
        check("s1_count",    ByteCount,         4);
        check("s1_nwr",      wr_count - w0,     4);
        check("s1_sb_empty", exp_q.size(),      0);
        check("s1_fetch0",   fetch0(),          32'h1300_5000);
        check("s1_ready",    bs.ByteReady,      0);

        // 2: length not a multiple of 4
        pulse_start();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h06};
        w0 = wr_count;
        send_all(0);
        check("s2_err",   Err,           1);
        check("s2_state", dbg_state,     ERR);
        check("s2_hold",  CpuHold,       1);
        check("s2_done",  Done,          0);
        tick(2);
        check("s2_nwr",   wr_count - w0, 0);
        check("s2_ready", bs.ByteReady,  0);

        // 3: bad checksum after full payload
        pulse_start();
        push_frame_1(8'h00);
        w0 = wr_count;
        send_all(0);
        check("s3_err",      Err,           1);
        check("s3_done",     Done,          0);
        check("s3_hold",     CpuHold,       1);
        check("s3_nwr",      wr_count - w0, 4);
        check("s3_sb_empty", exp_q.size(),  0);

        // 4: ByteValid toggling 1-0-1
        pulse_start();
        push_frame_1(8'h43);
        w0 = wr_count;
        send_all(1);
        check("s4_done",     Done,          1);
        check("s4_nwr",      wr_count - w0, 4);
        check("s4_sb_empty", exp_q.size(),  0);
        check("s4_fetch0",   fetch0(),      32'h1300_5000);

        // 5: reset after two payload bytes, then restart with Start and ByteValid together
        pulse_start();
        tx_q  = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00};
        exp_q = '{24'h0000_13, 24'h0001_00};
        send_all(0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("s5_state", dbg_state, IDLE);
        check("s5_count", ByteCount, 0);
        check("s5_hold",  CpuHold,   0);
        w0 = wr_count;
        tick(5);
        check("s5_nwr_after_rst", wr_count - w0, 0);
        check("s5_sb_empty",      exp_q.size(),  0);
        Start        = 1'b1;
        bs.ByteIn    = 8'h00;
        bs.ByteValid = 1'b1;
        tick(1);
        Start        = 1'b0;
        bs.ByteValid = 1'b0;
        push_frame_1(8'h43);
        w0 = wr_count;
        send_all(0);
        check("s5_done",  Done,          1);
        check("s5_nwr",   wr_count - w0, 4);
        check("s5_count", ByteCount,     4);

        // 6: full-memory image, then an oversize length
        pulse_start();
        sb_en = 1'b0;
        w0 = wr_count;
        tx_q = '{8'h00, 8'h01, 8'h00, 8'h00};
        send_all(0);
        for (int i = 0; i < (1 << WAD); i++) send_byte(8'hAA, 0);
        send_byte(8'h00, 0);
        check("s6_last_addr", last_addr,     16'hFFFF);
        check("s6_nwr",       wr_count - w0, 32'h1_0000);
        check("s6_count",     ByteCount,     17'h1_0000);
        check("s6_done",      Done,          1);
        check("s6_err",       Err,           0);
        sb_en = 1'b1;
        pulse_start();
        w0 = wr_count;
        tx_q = '{8'h00, 8'h01, 8'h00, 8'h04};
        send_all(0);
        tick(2);
        check("s6_big_err",   Err,           1);
        check("s6_big_state", dbg_state,     ERR);
        check("s6_big_nwr",   wr_count - w0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
